// File: rtl/sync_ram_dp_be_if.sv
// sync_ram_dp_be_if: write/read/clear bus of the byte-enabled dual-port RAM
interface sync_ram_dp_be_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int BE_W = DATA_W / 8;
  logic              clr_req;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_drop;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  modport master (
    output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  busy, wr_drop, rd_data, rd_valid
  );
  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output busy, wr_drop, rd_data, rd_valid
  );
endinterface

// File: rtl/sync_ram_dp_be.sv
// sync_ram_dp_be: simple dual-port RAM with byte enables and a sequential clear engine
module sync_ram_dp_be #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int RDW_MODE = 0,
  parameter int BE_W     = DATA_W / 8
) (
  input logic              clk,
  input logic              rst,
  sync_ram_dp_be_if.slave  bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q, wr_drop_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, merged;
  logic              wr_ok, rd_ok, rd_in;
  assign wr_ok = ~busy_q & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_ok = ~busy_q & bus.rd_en;
  assign rd_in = {1'b0, bus.rd_addr} < DEPTH_L;
  for (genvar b = 0; b < BE_W; b++) begin : g_merge
    assign merged[8*b +: 8] = bus.wr_be[b] ? bus.wr_data[8*b +: 8] : mem[bus.wr_addr][8*b +: 8];
  end
  // read word: zero outside the array, bypass of the merged write word in write-first mode
  always_comb begin
    rd_data_d = !rd_in ? '0 :
                (RDW_MODE == 1 && wr_ok && bus.wr_addr == bus.rd_addr) ? merged : mem[bus.rd_addr];
  end
  // storage: clear engine owns the array while busy, otherwise byte-masked writes
  always_ff @(posedge clk) begin
    if (!rst && busy_q) mem[cnt_q] <= '0;
    else if (!rst && wr_ok)
      for (int k = 0; k < BE_W; k++)
        if (bus.wr_be[k]) mem[bus.wr_addr][8*k +: 8] <= bus.wr_data[8*k +: 8];
  end
  // clear FSM plus registered read/drop outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      busy_q     <= 1'b1;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      wr_drop_q  <= bus.wr_en & ~wr_ok;
      rd_valid_q <= rd_ok;
      rd_data_q  <= rd_ok ? rd_data_d : rd_data_q;
      if (state_q == CLEAR) begin
        cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        state_q <= (cnt_q == LAST) ? IDLE : CLEAR;
        busy_q  <= cnt_q != LAST;
      end else begin
        cnt_q   <= '0;
        state_q <= bus.clr_req ? CLEAR : IDLE;
        busy_q  <= bus.clr_req;
      end
    end
  end
  assign bus.busy     = busy_q;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_sync_ram_dp_be.sv
// tb_sync_ram_dp_be: directed vectors and clear/reset/out-of-range sequences on three RAM configurations
module tb_sync_ram_dp_be;
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ed;
  } vec_t;
  logic        clk = 0, rst = 0, clr_req = 0, wr_en = 0, rd_en = 0;
  logic [3:0]  wr_addr = 0, rd_addr = 0, wr_be = 0;
  logic [31:0] wr_data = 0;
  int          checks = 0, errors = 0, n0, n2;
  vec_t        v [13];
  sync_ram_dp_be_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
  sync_ram_dp_be_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
  sync_ram_dp_be_if #(.DATA_W(8),  .ADDR_W(4)) b2 ();
  assign b0.clr_req = clr_req;
  assign b0.wr_en   = wr_en;
  assign b0.wr_addr = wr_addr;
  assign b0.wr_data = wr_data;
  assign b0.wr_be   = wr_be;
  assign b0.rd_en   = rd_en;
  assign b0.rd_addr = rd_addr;
  assign b1.clr_req = clr_req;
  assign b1.wr_en   = wr_en;
  assign b1.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;
  assign b1.wr_be   = wr_be;
  assign b1.rd_en   = rd_en;
  assign b1.rd_addr = rd_addr;
  assign b2.clr_req = clr_req;
  assign b2.wr_en   = wr_en;
  assign b2.wr_addr = wr_addr;
  assign b2.wr_data = wr_data[7:0];
  assign b2.wr_be   = wr_be[0];
  assign b2.rd_en   = rd_en;
  assign b2.rd_addr = rd_addr;
  sync_ram_dp_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  sync_ram_dp_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RDW_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  sync_ram_dp_be #(.DATA_W(8),  .ADDR_W(4), .DEPTH(12), .RDW_MODE(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic idle;
    wr_en = 0; rd_en = 0; clr_req = 0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask
  task automatic rd(input logic [3:0] a);
    rd_en = 1; rd_addr = a;
  endtask
  task automatic read_all_zero(input string n);
    for (int i = 0; i < 16; i++) begin
      idle; rd(4'(i)); step;
      chk({n, "_valid"}, 32'(b0.rd_valid), 1);
      chk({n, "_data0"}, b0.rd_data, 0);
      chk({n, "_data1"}, b1.rd_data, 0);
    end
    idle;
  endtask
  initial begin
    v[0]  = '{1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,        32'h0,        0};
    v[1]  = '{1, 5, 32'h000000AA, 4'h1, 0, 0, 0, 32'h0,        32'h0,        0};
    v[2]  = '{0, 0, 32'h0,        4'h0, 1, 5, 1, 32'hDEADBEAA, 32'hDEADBEAA, 0};
    v[3]  = '{1, 3, 32'h00000011, 4'hF, 0, 0, 0, 32'hDEADBEAA, 32'hDEADBEAA, 0};
    v[4]  = '{1, 3, 32'h00000022, 4'hF, 1, 3, 1, 32'h00000011, 32'h00000022, 0};
    v[5]  = '{0, 0, 32'h0,        4'h0, 1, 3, 1, 32'h00000022, 32'h00000022, 0};
    v[6]  = '{1, 7, 32'h12345678, 4'h0, 1, 5, 1, 32'hDEADBEAA, 32'hDEADBEAA, 0};
    v[7]  = '{0, 0, 32'h0,        4'h0, 1, 7, 1, 32'h0,        32'h0,        0};
    v[8]  = '{1, 9, 32'hCAFEF00D, 4'hA, 1, 9, 1, 32'h0,        32'hCA00F000, 0};
    v[9]  = '{0, 0, 32'h0,        4'h0, 1, 9, 1, 32'hCA00F000, 32'hCA00F000, 0};
    v[10] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 32'hCA00F000, 32'hCA00F000, 0};
    v[11] = '{1, 4, 32'h55667788, 4'hF, 1, 9, 1, 32'hCA00F000, 32'hCA00F000, 0};
    v[12] = '{0, 0, 32'h0,        4'h0, 1, 4, 1, 32'h55667788, 32'h55667788, 0};
    rst = 1; step;
    chk("rst_busy", 32'(b0.busy), 1);
    chk("rst_valid", 32'(b0.rd_valid), 0);
    chk("rst_data", b0.rd_data, 0);
    chk("rst_drop", 32'(b0.wr_drop), 0);
    rst = 0;
    n0 = 32'(b0.busy); n2 = 32'(b2.busy);
    for (int i = 0; i < 20; i++) begin
      step; n0 += 32'(b0.busy); n2 += 32'(b2.busy);
    end
    chk("busy_len16", n0, 16);
    chk("busy_len12", n2, 12);
    read_all_zero("init_rd");
    for (int i = 0; i < 13; i++) begin
      idle;
      if (v[i].we) wr(v[i].wa, v[i].wd, v[i].be);
      if (v[i].re) rd(v[i].ra);
      step;
      chk($sformatf("v%0d_valid0", i), 32'(b0.rd_valid), 32'(v[i].ev));
      chk($sformatf("v%0d_valid1", i), 32'(b1.rd_valid), 32'(v[i].ev));
      chk($sformatf("v%0d_data0", i), b0.rd_data, v[i].e0);
      chk($sformatf("v%0d_data1", i), b1.rd_data, v[i].e1);
      chk($sformatf("v%0d_drop", i), 32'(b0.wr_drop), 32'(v[i].ed));
    end
    idle;
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 32'hA5A5A5A5, 4'hF); step;
    end
    idle; rd(2); step;
    chk("fill_rd", b0.rd_data, 32'hA5A5A5A5);
    idle; clr_req = 1; step;
    chk("clr_busy", 32'(b0.busy), 1);
    n0 = 32'(b0.busy);
    idle; wr(2, 32'h00001234, 4'hF); step;
    chk("busy_drop", 32'(b0.wr_drop), 1);
    n0 += 32'(b0.busy);
    idle; rd(3); clr_req = 1; step;
    chk("busy_rd_valid", 32'(b0.rd_valid), 0);
    chk("busy_rd_hold", b0.rd_data, 32'hA5A5A5A5);
    n0 += 32'(b0.busy);
    idle; step;
    chk("drop_pulse", 32'(b0.wr_drop), 0);
    n0 += 32'(b0.busy);
    for (int i = 0; i < 20; i++) begin
      step; n0 += 32'(b0.busy);
    end
    chk("clr_len", n0, 16);
    read_all_zero("clr_rd");
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 32'h5A5A5A5A, 4'hF); step;
    end
    idle; clr_req = 1; step;
    idle;
    for (int i = 0; i < 7; i++) step;
    rst = 1; step;
    chk("rst_mid_busy", 32'(b0.busy), 1);
    rst = 0;
    n0 = 32'(b0.busy);
    for (int i = 0; i < 20; i++) begin
      step; n0 += 32'(b0.busy);
    end
    chk("rst_mid_len", n0, 16);
    read_all_zero("rst_mid_rd");
    for (int i = 0; i < 12; i++) begin
      wr(4'(i), 32'h30 + 32'(i), 4'hF); step;
    end
    idle; rd(11); step;
    chk("oor_pre_valid", 32'(b2.rd_valid), 1);
    chk("oor_pre_data", 32'(b2.rd_data), 32'h3B);
    idle; wr(13, 32'h000000FF, 4'hF); step;
    chk("oor_drop12", 32'(b2.wr_drop), 1);
    chk("oor_drop16", 32'(b0.wr_drop), 0);
    idle; rd(13); step;
    chk("oor_rd_valid", 32'(b2.rd_valid), 1);
    chk("oor_rd_data", 32'(b2.rd_data), 0);
    chk("oor_rd_data16", b0.rd_data, 32'hFF);
    chk("oor_drop_end", 32'(b2.wr_drop), 0);
    for (int i = 0; i < 12; i++) begin
      idle; rd(4'(i)); step;
      chk($sformatf("oor_keep%0d", i), 32'(b2.rd_data), 32'h30 + 32'(i));
    end
    idle; step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_ram_dp_be.md
Name: sync_ram_dp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one registered read port.
- Contents are cleared by a hardware clear sequencer, which runs after reset and on request.
- Replaces fixed 16x8 single-port RAM instances; general scratch and buffer storage for datapath blocks.
- Clear is sequential (one word per cycle) so the array maps to block RAM rather than flops.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; 2 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write: 0 = old data (read-first), 1 = new merged data (write-first).
- BE_W, DATA_W/8, byte-enable width (derived; do not override).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- clr_req, input, 1, single-cycle request to start a clear sequence.
- busy, output, 1, high while the clear sequence runs.
- wr_en, input, 1, write strobe.
- wr_addr, input, ADDR_W, write address.
- wr_data, input, DATA_W, write data.
- wr_be, input, BE_W, byte enables; bit k covers wr_data[8k+7:8k].
- wr_drop, output, 1, one-cycle pulse when a write is discarded.
- rd_en, input, 1, read strobe.
- rd_addr, input, ADDR_W, read address.
- rd_data, output, DATA_W, registered read data.
- rd_valid, output, 1, high the cycle after an accepted read.

Behaviour:
- Reset: reset is clk, synchronous, active-high.
  - On a rst edge: rd_data=0, rd_valid=0, wr_drop=0, clear counter=0, FSM -> CLEAR.
  - So busy=1 from the first edge after rst is asserted.
  - Memory is not cleared in the rst cycle itself; the clear sequence does it.
- FSM states: IDLE and CLEAR. busy is registered and equals (state==CLEAR).
- CLEAR:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - On the cycle that writes DEPTH-1: cnt -> 0 and state -> IDLE.
  - busy is high for exactly DEPTH cycles.
  - rst during CLEAR restarts the sequence at address 0.
- IDLE: clr_req=1 -> CLEAR with cnt=0 on the next edge.
- clr_req while busy is ignored; the sequence is not extended.
- Writes in IDLE:
  - wr_en=1 updates mem[wr_addr] only in bytes where wr_be[k]=1, at the clock edge.
  - wr_be=0 leaves the word unchanged and is not a drop.
- Reads in IDLE:
  - rd_en=1 -> rd_data valid on the next edge with rd_valid=1; latency 1.
  - rd_en=0 -> rd_valid=0 and rd_data holds its last value.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: rd_data = the word before the write.
  - RDW_MODE=1: rd_data = the post-write word (enabled bytes from wr_data, the rest from the old word).
  - Different addresses: independent, no interaction.
- While busy:
  - wr_en=1 is discarded and wr_drop=1 on the next edge.
  - rd_en=1 is ignored: rd_valid=0 and rd_data unchanged.
- clr_req and wr_en in the same IDLE cycle: the write is performed, and the clear starts next cycle (so it overwrites that word).
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write: discarded, wr_drop=1.
  - Read: rd_valid=1, rd_data=0.
- wr_drop is a single-cycle registered pulse, 0 otherwise.
- No X propagation: every bit of every location is defined after the first clear completes.

Test Plan:
- Reset/clear: assert rst 1 cycle with defaults → busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0x00 with rd_valid=1 one cycle after each rd_en.
- Basic write/read at DATA_W=32, ADDR_W=4, DEPTH=16:
  - Write 0xDEADBEEF to addr 5, be=4'b1111.
  - Then write 0x000000AA to addr 5, be=4'b0001.
  - Read addr 5 → 0xDEADBEAA one cycle later.
- Read-during-write: mem[3]=0x11; write 0x22 to addr 3 and read addr 3 in the same cycle.
  - RDW_MODE=0 → rd_data=0x11.
  - RDW_MODE=1 → rd_data=0x22.
  - The following read of addr 3 → 0x22 in both modes.
- Clear mid-traffic:
  - Fill all 16 words with 0xA5, then pulse clr_req.
  - Issue a write to addr 2 during busy → wr_drop=1 one cycle later.
  - Issue a read during busy → rd_valid=0.
  - After busy falls, all words read 0x00.
- Reset mid-clear: assert rst when cnt=7 → busy stays high for 16 further cycles from address 0; all words 0 afterwards.
- Out-of-range with DEPTH=12, ADDR_W=4:
  - Write addr 13 → wr_drop=1.
  - Read addr 13 → rd_valid=1, rd_data=0.
  - mem[0..11] unchanged.
